// File: rtl/sync_bus_arbiter.sv
// sync_bus_arbiter: round-robin front end for a shared DATA_SYNC crossing.
// Launches one requester word at a time onto unsync_bus and frames it with a
// bus_enable level that stays high for HOLD_CYCLES, then low for at least
// GAP_CYCLES+1 cycles so every word gives the destination a fresh rising edge.
module sync_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [BUS_WIDTH-1:0]          unsync_bus,
  output logic                          bus_enable
);

  localparam int GID_W   = $clog2(NUM_REQ);
  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  // The counter only ever holds load values (HOLD/GAP minus one), so
  // clog2 of the larger one is enough; keep at least one bit.
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [GID_W-1:0] LAST_RST  = GID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [GID_W-1:0]      last_grant, last_n;
  logic [GID_W-1:0]      gid_n;
  logic [NUM_REQ-1:0]    ack_n;
  logic [BUS_WIDTH-1:0]  bus_n;
  logic                  en_n;

  logic [BUS_WIDTH-1:0]  words [NUM_REQ];
  logic [GID_W-1:0]      winner;
  logic [GID_W-1:0]      idx;

  // Split the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // Round-robin pick: scan from the farthest candidate down to last_grant+1
  // so the nearest set bit after the previous winner overwrites the others.
  always_comb begin
    winner = last_grant;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  // Next-state and next-output logic; every output is registered, so this
  // block computes what the outputs become on the coming edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last_grant;
    gid_n   = grant_id;
    ack_n   = '0;
    bus_n   = unsync_bus;
    en_n    = bus_enable;
    case (state)
      IDLE: begin
        if (|req) begin
          bus_n         = words[winner];
          en_n          = 1'b1;
          ack_n[winner] = 1'b1;
          gid_n         = winner;
          last_n        = winner;
          cnt_n         = HOLD_LOAD;
          state_n       = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          en_n    = 1'b0;
          cnt_n   = GAP_LOAD;
          state_n = GAP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; an in-flight word is
  // simply dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= LAST_RST;
      grant_id   <= '0;
      ack        <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_n;
      grant_id   <= gid_n;
      ack        <= ack_n;
      unsync_bus <= bus_n;
      bus_enable <= en_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sync_bus_arbiter.sv
// tb_sync_bus_arbiter: scenario tasks plus randomized traffic, all checked
// against a timeline model of launches kept in the bench.
module tb_sync_bus_arbiter;

  localparam int NR = 4;
  localparam int BW = 8;
  localparam int H  = 4;
  localparam int G  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0]   ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic [BW-1:0]   unsync_bus;
  logic            bus_enable;

  logic [NR-1:0]   req_m;
  logic [NR*BW-1:0] data_m;
  logic [NR-1:0]   ack_m;
  logic [1:0]      gid_m;
  logic            busy_m;
  logic [BW-1:0]   bus_m;
  logic            en_m;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: outputs expected after the latest edge.
  int            cyc = 0;
  int            m_launch = 0;
  bit            m_active = 1'b0;
  logic [NR-1:0] m_ack = '0;
  logic [1:0]    m_gid = '0;
  logic [1:0]    m_last = 2'd3;
  logic          m_busy = 1'b0;
  logic [BW-1:0] m_bus = '0;
  logic          m_en = 1'b0;

  logic [15:0] obs, expv;
  assign obs  = {ack, grant_id, busy, unsync_bus, bus_enable};
  assign expv = {m_ack, m_gid, m_busy, m_bus, m_en};

  sync_bus_arbiter #(.NUM_REQ(NR), .BUS_WIDTH(BW), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .unsync_bus(unsync_bus), .bus_enable(bus_enable)
  );

  sync_bus_arbiter #(.NUM_REQ(NR), .BUS_WIDTH(BW), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_min (
    .clk(clk), .rst(rst), .req(req_m), .req_data(data_m), .ack(ack_m),
    .grant_id(gid_m), .busy(busy_m), .unsync_bus(bus_m), .bus_enable(en_m)
  );

  always #5 clk = ~clk;

  // Timeline model: a launch may happen on an edge only if the previous
  // cycle was idle, i.e. H+G cycles have passed since the last launch.
  task automatic model_edge();
    int  w;
    bit  found;
    logic [NR*BW-1:0] d;
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_ack = '0; m_gid = '0; m_last = 2'(NR - 1);
      m_busy = 1'b0; m_bus = '0; m_en = 1'b0;
    end else begin
      m_ack = '0;
      if ((!m_active || (cyc - 1 - m_launch) >= H + G) && req != '0) begin
        found = 1'b0;
        w = 0;
        for (int k = 1; k <= NR; k++) begin
          if (!found && req[(int'(m_last) + k) % NR]) begin
            found = 1'b1;
            w = (int'(m_last) + k) % NR;
          end
        end
        d = req_data;
        m_launch = cyc;
        m_active = 1'b1;
        m_bus = d[w*BW +: BW];
        m_ack[w] = 1'b1;
        m_gid = 2'(w);
        m_last = 2'(w);
      end
      m_en   = m_active && ((cyc - m_launch) < H);
      m_busy = m_active && ((cyc - m_launch) < H + G);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0;
    step();
    step();
    n_checks++;
    if (obs !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 16'h0000);
    end
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL reset_model: got %h expected %h", obs, expv);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int en_high = 0;
    do_reset();
    req = 4'b0100;
    req_data = 32'h00A5_0000;
    for (int i = 0; i < 14; i++) begin
      step();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("[TB] FAIL single cyc%0d: got %h expected %h", i, obs, expv);
      end
      if (ack[2]) req = '0;
      if (bus_enable) en_high++;
    end
    n_checks++;
    if (en_high !== H) begin
      n_fail++;
      $display("[TB] FAIL single_en_len: got %0d expected %0d", en_high, H);
    end
    n_checks++;
    if (grant_id !== 2'd2 || unsync_bus !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL single_word: got gid %0d bus %h expected gid 2 bus a5", grant_id, unsync_bus);
    end
  endtask

  task automatic test_all_requesting();
    logic [1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [BW-1:0] seen_word [$];
    logic [1:0]    seen_gid [$];
    int            seen_cyc [$];
    logic          prev_en;
    do_reset();
    req = 4'b1111;
    req_data = 32'h1312_1110;
    prev_en = bus_enable;
    for (int i = 0; i < 5 * (H + G + 1) + 2; i++) begin
      step();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("[TB] FAIL all_req cyc%0d: got %h expected %h", i, obs, expv);
      end
      if (bus_enable && !prev_en) begin
        seen_word.push_back(unsync_bus);
        seen_gid.push_back(grant_id);
        seen_cyc.push_back(i);
      end
      prev_en = bus_enable;
    end
    n_checks++;
    if (seen_word.size() < 5) begin
      n_fail++;
      $display("[TB] FAIL all_req_count: got %0d launches expected 5", seen_word.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (seen_word[k] !== 8'h10 + BW'(exp_order[k]) || seen_gid[k] !== exp_order[k]) begin
          n_fail++;
          $display("[TB] FAIL all_req_order%0d: got gid %0d word %h expected gid %0d word %h",
                   k, seen_gid[k], seen_word[k], exp_order[k], 8'h10 + BW'(exp_order[k]));
        end
        if (k > 0) begin
          n_checks++;
          if (seen_cyc[k] - seen_cyc[k-1] != H + G + 1) begin
            n_fail++;
            $display("[TB] FAIL all_req_period%0d: got %0d expected %0d", k, seen_cyc[k] - seen_cyc[k-1], H + G + 1);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] grants [$];
    int phase = 0;
    do_reset();
    req = 4'b1000;
    req_data = 32'h3300_0044;
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("[TB] FAIL wrap cyc%0d: got %h expected %h", i, obs, expv);
      end
      if (ack != '0) grants.push_back(grant_id);
      if (ack[3] && phase == 0) begin
        req = 4'b1001;
        phase = 1;
      end
    end
    n_checks++;
    if (grants.size() < 3) begin
      n_fail++;
      $display("[TB] FAIL wrap_count: got %0d grants expected 3", grants.size());
    end else begin
      n_checks++;
      if (grants[0] !== 2'd3 || grants[1] !== 2'd0 || grants[2] !== 2'd3) begin
        n_fail++;
        $display("[TB] FAIL wrap_order: got %0d,%0d,%0d expected 3,0,3", grants[0], grants[1], grants[2]);
      end
    end
  endtask

  task automatic test_withdrawn();
    int k0 = -1;
    int early = 0;
    int late = 0;
    do_reset();
    req = 4'b0001;
    req_data = 32'h0000_6655;
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("[TB] FAIL withdrawn cyc%0d: got %h expected %h", i, obs, expv);
      end
      if (ack[1]) begin
        if (i < 13) early++;
        else late++;
        req[1] = 1'b0;
      end
      if (ack[0] && k0 < 0) begin
        k0 = i;
        req = 4'b0010;
      end else if (k0 >= 0 && i == k0 + 2) begin
        req = 4'b0000;
      end
      if (i == 12) req = 4'b0010;
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("[TB] FAIL withdrawn_pulse: got %0d acks expected 0", early);
    end
    n_checks++;
    if (late !== 1) begin
      n_fail++;
      $display("[TB] FAIL withdrawn_held: got %0d acks expected 1", late);
    end
  endtask

  task automatic test_reset_mid_hold();
    int first_gid = -1;
    do_reset();
    req = 4'b0001;
    req_data = 32'h0000_0077;
    step();
    n_checks++;
    if (ack !== 4'b0001 || unsync_bus !== 8'h77) begin
      n_fail++;
      $display("[TB] FAIL midhold_launch: got ack %b bus %h expected ack 0001 bus 77", ack, unsync_bus);
    end
    req = '0;
    step();
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (bus_enable !== 1'b0 || unsync_bus !== 8'h00 || busy !== 1'b0 || obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL midhold_reset: got %h expected %h", obs, expv);
    end
    rst = 1'b0;
    req = 4'b0011;
    req_data = 32'h0000_2211;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("[TB] FAIL midhold_after cyc%0d: got %h expected %h", i, obs, expv);
      end
      if (ack != '0 && first_gid < 0) begin
        first_gid = int'(grant_id);
        req = '0;
      end
    end
    n_checks++;
    if (first_gid != 0) begin
      n_fail++;
      $display("[TB] FAIL midhold_grant: got %0d expected 0", first_gid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = NR'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = '0;
      req_data = $urandom;
      step();
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("[TB] FAIL random cyc%0d: got %h expected %h", i, obs, expv);
      end
      n_checks++;
      if (!$onehot0(ack)) begin
        n_fail++;
        $display("[TB] FAIL random_onehot cyc%0d: got ack %b expected at most one bit", i, ack);
      end
    end
    req = '0;
  endtask

  task automatic test_min_params();
    logic exp_en;
    logic exp_busy;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_m = 4'b0001;
    data_m = 32'h0000_00C3;
    for (int i = 1; i <= 15; i++) begin
      step();
      exp_en   = ((i - 1) % 3) == 0;
      exp_busy = ((i - 1) % 3) != 2;
      n_checks++;
      if (en_m !== exp_en || ack_m !== {3'b000, exp_en} || busy_m !== exp_busy || bus_m !== 8'hC3) begin
        n_fail++;
        $display("[TB] FAIL min_params cyc%0d: got en %b ack %b busy %b bus %h expected en %b ack %b busy %b bus c3",
                 i, en_m, ack_m, busy_m, bus_m, exp_en, {3'b000, exp_en}, exp_busy);
      end
    end
    req_m = '0;
  endtask

  // Runaway guard in case the run ever stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    req_m = '0;
    data_m = '0;
    test_reset();
    test_single();
    test_all_requesting();
    test_wrap();
    test_withdrawn();
    test_reset_mid_hold();
    test_random();
    test_min_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_bus_arbiter.md
# sync_bus_arbiter

Source-domain controller that shares one DATA_SYNC clock-domain crossing among several requesters. It arbitrates round-robin, launches one word at a time onto the crossing's `unsync_bus`, and drives `bus_enable` as a level. The enable is held high long enough for the destination to detect a rising edge, then returned low for a guaranteed gap so consecutive words produce distinct `enable_pulse` events. The block sits in the sending clock domain, directly in front of the DATA_SYNC instance.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `BUS_WIDTH`, default 8: word width; must match DATA_SYNC `BUS_WIDTH`.
- `HOLD_CYCLES`, default 4: cycles `bus_enable` stays high; must be ≥ 1. The integrator sizes it to cover destination `NUM_STAGES` plus 2 destination clocks.
- `GAP_CYCLES`, default 4: minimum low time of `bus_enable` is `GAP_CYCLES` + 1 cycles; must be ≥ 1.
- `clk` input 1: single clock. All logic is posedge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NUM_REQ: per-requester request level. Bit i belongs to requester i.
- `req_data` input NUM_REQ*BUS_WIDTH: requester i's word is bits `[i*BUS_WIDTH +: BUS_WIDTH]`.
- `ack` output NUM_REQ: registered one-cycle pulse; word i has been accepted.
- `grant_id` output $clog2(NUM_REQ): index of the most recently launched requester.
- `busy` output 1: high while state ≠ IDLE.
- `unsync_bus` output BUS_WIDTH: registered word driven to DATA_SYNC.
- `bus_enable` output 1: registered level driven to DATA_SYNC.

## Operation
- FSM states: IDLE, HOLD, GAP. One down-counter, width sized for max(HOLD_CYCLES, GAP_CYCLES).
- **IDLE**
  - If `req` ≠ 0, pick the winner w: the first set bit searching upward from `last_grant`+1, wrapping modulo NUM_REQ.
  - On that edge: `unsync_bus` ← word w; `bus_enable` ← 1; `ack[w]` ← 1; `grant_id`, `last_grant` ← w; counter ← HOLD_CYCLES−1; next state HOLD.
  - If `req` = 0, stay in IDLE; all outputs hold their values except `ack`, which is 0.
- **HOLD**
  - `ack` ← 0.
  - If counter = 0: `bus_enable` ← 0; counter ← GAP_CYCLES−1; next state GAP.
  - Otherwise decrement the counter.
- **GAP**
  - If counter = 0, next state IDLE.
  - Otherwise decrement the counter.
- `unsync_bus` changes only on a launch edge. It stays stable through HOLD, GAP and IDLE.
- Requester rules:
  - Keep `req` and the data stable until `ack` is seen.
  - `req` is sampled only in IDLE, so deasserting it before `ack` withdraws the request cleanly.
  - `req` still high in the cycle after `ack` is a new request.
- Only one `ack` bit is ever high in a cycle.
- Reset values: state IDLE, counter 0, `last_grant` = NUM_REQ−1 (so requester 0 wins first), and `unsync_bus`, `bus_enable`, `ack`, `grant_id`, `busy` all 0.
- Reset mid-operation: all outputs reach reset values on the next edge. An in-flight word is abandoned and its `ack` is not reissued.

## Timing
- Latency: with `req[i]` high in cycle t-1 while IDLE, `ack[i]`, `bus_enable` and the new `unsync_bus` are all high/valid in cycle t.
- `bus_enable` is high in cycles t .. t+HOLD_CYCLES−1 and low from t+HOLD_CYCLES.
- The earliest next launch makes `bus_enable` high at t+HOLD_CYCLES+GAP_CYCLES+1.
- Launch period is HOLD_CYCLES+GAP_CYCLES+1 cycles. Defaults give 9 cycles per word.
- `busy` is high from cycle t through t+HOLD_CYCLES+GAP_CYCLES−1, and low in the IDLE cycle that precedes the next launch.
- Simultaneous requests are resolved by round-robin only. Under continuous full load each requester is served once every NUM_REQ launches.

## Test plan
- **Single request:** `req`=4'b0100, data2=8'hA5 after reset → `ack`=4'b0100 for 1 cycle; `unsync_bus`=A5; `bus_enable` high exactly 4 cycles, then low ≥5; `grant_id`=2.
- **All requesting:** `req`=4'b1111 held after each ack with data i=8'h10+i → grant order 0,1,2,3,0; launches 9 cycles apart; DATA_SYNC model output sequence 10,11,12,13,10.
- **Round-robin wrap:** last grant 3, then `req`=4'b1001 → grant 0. Next request with `req`=4'b1001 → grant 3.
- **Withdrawn request:** `req[1]` pulsed for 2 cycles during HOLD of a requester-0 word → never acked. `req[1]` held until IDLE → acked.
- **Reset mid-HOLD:** `rst` asserted 2 cycles into HOLD → next edge `bus_enable`=0, `unsync_bus`=0, `busy`=0. After release, `req`=4'b0011 → grant 0.
- **Minimum parameters (HOLD_CYCLES=1, GAP_CYCLES=1):** continuous `req`=4'b0001 → `bus_enable` high 1 cycle, low 2 cycles, period 3; one `ack` per period.
